byte_lane_memory: RTL
=====================

// Module: byte_lane_memory
// PURPOSE
//  Synchronous, byte-addressable data memory for the single-cycle/multi-cycle core datapath.
//  Little-endian; byte, half and word (and dword if DATA_WIDTH=64) accesses; optional sign extension.
//  Uses a valid/ready request handshake and a fixed 1-cycle response.
//  Flags misaligned and out-of-range accesses.
//  Zero-fills its contents after reset.
// PARAMETERS
//  DATA_WIDTH      32   word width in bits; 32 or 64 only (BYTES = DATA_WIDTH/8)
//  ADDR_WIDTH      18   byte-address width
//  DEPTH_WORDS     256  number of DATA_WIDTH words; byte range 0 .. DEPTH_WORDS*BYTES-1
//  CLEAR_ON_RESET  1    1: zero-fill sequence after reset; 0: contents undefined, ready at once
// PORTS
//  clk             in   1           rising-edge clock
//  reset           in   1           synchronous, active-high
//  req_valid       in   1           request present
//  req_ready       out  1           request accepted when req_valid && req_ready
//  memWrite        in   1           1 = store, 0 = load
//  access_size     in   2           00 byte, 01 half, 10 word, 11 dword (legal only when DATA_WIDTH=64)
//  load_signed     in   1           loads: 1 = sign-extend, 0 = zero-extend
//  address         in   ADDR_WIDTH  byte address
//  write_data      in   DATA_WIDTH  store data, LSB-aligned
//  resp_valid      out  1           one-cycle pulse, response to the previously accepted request
//  read_data       out  DATA_WIDTH  load result, LSB-aligned and extended; 0 for stores and errors
//  access_err      out  1           qualified by resp_valid: misaligned, out-of-range or illegal size
//  busy            out  1           high while zero-fill runs
// BEHAVIOUR
//  Clock and reset
//  - One clock, clk. Reset is synchronous and active-high on port reset.
//  - Reset values: req_ready=0, resp_valid=0, read_data=0, access_err=0, busy=CLEAR_ON_RESET.
//  State machine
//  - States: CLEAR, IDLE. Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
//  - CLEAR: a counter writes 0 to word 0 .. DEPTH_WORDS-1, one word per cycle.
//  - After exactly DEPTH_WORDS cycles in CLEAR: go to IDLE, busy=0, req_ready=1.
//  - IDLE: req_ready=1 every cycle. Any reset restarts from the reset state.
//  Lane and alignment
//  - Byte lane = address[log2(BYTES)-1:0]; word index = address >> log2(BYTES).
//  - Aligned when address is a multiple of (1<<access_size).
//  Request errors
//  - Error if misaligned, word index >= DEPTH_WORDS, or size 11 with DATA_WIDTH=32.
//  - An error request is accepted normally, but memory is unchanged.
//  - Its response has resp_valid=1, access_err=1, read_data=0.
//  Stores
//  - Accepted store updates only the addressed bytes at the accepting edge; other bytes keep their value.
//  - Response next cycle: resp_valid=1, read_data=0.
//  Loads
//  - Accepted load: read_data valid on the cycle after acceptance (latency 1, resp_valid=1).
//  - Extension per load_signed from bit 8*(1<<size)-1.
//  Ordering and backpressure
//  - A load accepted in cycle N+1 after a store to the same bytes in cycle N returns the new data.
//  - No response backpressure: the consumer must take every resp_valid pulse.
//  - Back-to-back requests give back-to-back responses.
//  - resp_valid=0 in cycles with no accepted request; read_data/access_err then hold their last value.
//  Reset mid-operation
//  - A pending response is dropped: resp_valid=0 the next cycle.
//  - Memory is re-cleared when CLEAR_ON_RESET=1.
// STRUCTURE
//  Shared package mem_pkg
//  - Localparams SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_DWORD=2'b11.
//  - State encodings ST_CLEAR, ST_IDLE.
//  Sub-module lane_align_extend (combinational)
//  - Store path: builds the byte-enable mask and lane-shifted write data.
//  - Load path: extracts, shifts and sign/zero-extends load data.
//  Top level
//  - Holds the byte-enabled storage array, the FSM with clear counter, and the response registers.
// TESTING
//  1. Reset held 2 cycles, CLEAR_ON_RESET=1, DEPTH_WORDS=256 -> busy=1, req_ready=0 for 256 cycles after release; word load of 0x3FC -> 0.
//  2. Store word 0xDEADBEEF @0x10, then byte load @0x11 unsigned -> 0x000000BE.
//     Then byte load @0x13 signed -> 0xFFFFFFDE; half load @0x12 signed -> 0xFFFFDEAD.
//  3. Store byte 0x55 @0x21 over word 0x11223344 @0x20 -> word load @0x20 = 0x11225544.
//  4. Half store @0x31 -> access_err=1 next cycle, word @0x30 unchanged; word load @DEPTH_WORDS*4 -> access_err=1, read_data=0.
//  5. Back-to-back: store 0xA5A5A5A5 @0x40 in cycle N, load @0x40 in N+1 -> resp N+2 = 0xA5A5A5A5, resp_valid high N+1 and N+2.
//  6. Load accepted, reset asserted the following cycle -> resp_valid=0, busy=1; store before reset reads 0 after clear.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared access-size codes, FSM states and alignment helper for the byte-lane data memory.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [7:0] align_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 8'h00;
            SIZE_HALF: return 8'h01;
            SIZE_WORD: return 8'h03;
            default:   return 8'h07;
        endcase
    endfunction

endpackage

// File: rtl/lane_align_extend.sv
// Lane steering: byte-enable mask and shifted store data, plus load extract with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module lane_align_extend
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] lane,
    input  logic [1:0]                      access_size,
    input  logic                            load_signed,
    input  logic [DATA_WIDTH-1:0]           write_data,
    input  logic [DATA_WIDTH-1:0]           word_data,
    output logic [DATA_WIDTH/8-1:0]         byte_en,
    output logic [DATA_WIDTH-1:0]           lane_wdata,
    output logic [DATA_WIDTH-1:0]           load_data
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam logic [1:0] MAX_SIZE = 2'(LANE_W);

    logic [1:0]            size_eff;
    int                    nbytes;
    logic [BYTES-1:0]      low_en;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep_mask;
    logic                  sign;

    // An illegal dword on a 32-bit memory is clamped to word width; the top flags it as an error.
    always_comb begin
        size_eff  = (access_size > MAX_SIZE) ? MAX_SIZE : access_size;
        nbytes    = 1 << size_eff;
        low_en    = '0;
        keep_mask = '0;
        sign      = 1'b0;
        shifted   = word_data >> {lane, 3'b000};
        for (int i = 0; i < BYTES; i++) begin
            low_en[i]            = (i < nbytes);
            keep_mask[8*i +: 8]  = {8{i < nbytes}};
            if (i == nbytes - 1) begin
                sign = shifted[8*i + 7];
            end
        end
        byte_en    = low_en << lane;
        lane_wdata = write_data << {lane, 3'b000};
        load_data  = (load_signed && sign) ? (shifted | ~keep_mask) : (shifted & keep_mask);
    end

endmodule

// File: rtl/byte_lane_memory.sv
// Byte-addressable little-endian data memory with zero-fill after reset and error flagging.
// Latency: 1 cycle from accepted request to resp_valid pulse; stores commit at the accepting edge.
// Backpressure: req_ready low only during zero-fill; responses cannot be stalled.
module byte_lane_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 18,
    parameter int DEPTH_WORDS    = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  memWrite,
    input  logic [1:0]            access_size,
    input  logic                  load_signed,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  access_err,
    output logic                  busy
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = ADDR_WIDTH - LANE_W;
    localparam int CNT_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      clr_cnt;

    logic [LANE_W-1:0]     lane;
    logic [IDX_W-1:0]      word_idx;
    logic [CNT_W-1:0]      mem_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  bad_size;
    logic                  req_err;
    logic                  accept;
    logic [BYTES-1:0]      byte_en;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] load_data;

    assign lane         = address[LANE_W-1:0];
    assign word_idx     = address[ADDR_WIDTH-1:LANE_W];
    assign mem_idx      = word_idx[CNT_W-1:0];
    assign misaligned   = (lane & LANE_W'(align_mask(access_size))) != '0;
    assign out_of_range = ADDR_WIDTH'(word_idx) >= ADDR_WIDTH'(DEPTH_WORDS);
    assign bad_size     = (access_size == SIZE_DWORD) && (BYTES < 8);
    assign req_err      = misaligned || out_of_range || bad_size;
    assign accept       = req_valid && req_ready && !reset;
    assign rd_word      = mem[mem_idx];

    lane_align_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .lane        (lane),
        .access_size (access_size),
        .load_signed (load_signed),
        .write_data  (write_data),
        .word_data   (rd_word),
        .byte_en     (byte_en),
        .lane_wdata  (lane_wdata),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == CNT_W'(DEPTH_WORDS - 1)) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: next_state = ST_IDLE;
        endcase
    end

    // Ready/busy are registered off next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            busy      <= CLEAR_ON_RESET;
        end else begin
            clr_cnt   <= (state == ST_CLEAR) ? clr_cnt + CNT_W'(1) : '0;
            req_ready <= (next_state == ST_IDLE);
            busy      <= (next_state == ST_CLEAR);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (accept && memWrite && !req_err) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (byte_en[i]) begin
                        mem[mem_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // read_data/access_err hold between responses; stores and errors return zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            read_data  <= '0;
            access_err <= 1'b0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                access_err <= req_err;
                read_data  <= (req_err || memWrite) ? '0 : load_data;
            end
        end
    end

endmodule
